sdram_burst_master: RTL and testbench
=====================================

SDRAM_BURST_MASTER -- requirements
Module: sdram_burst_master

Interface
REQ-001 Parameter: RD_FIFO_DEPTH, default 4, read-data FIFO depth in words (power of 2, 2..16).
REQ-002 Parameter: MAX_LEN, default 256, maximum burst length in words.
REQ-003 clk_i  in  1  single clock; all logic rising-edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1  burst command handshake; transfer on both high.
REQ-006 cmd_we_i  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr_i  in  32  start word address.
REQ-008 cmd_len_i  in  9  word count, 0..MAX_LEN.
REQ-009 wr_valid_i / wr_ready_o / wr_data_i  in/out/in  1/1/16  write-data stream.
REQ-010 rd_valid_o / rd_ready_i / rd_data_o  out/in/out  1/1/16  read-data stream (FIFO head).
REQ-011 done_o  out  1  one-cycle pulse at burst completion.
REQ-012 m_stb_o, m_we_o, m_addr_o[31:0], m_dat_o[15:0]  out  request to downstream SDRAM bus port.
REQ-013 m_cyc_i  in  1  downstream cycle-active; m_dat_i[15:0]  in  downstream read data.

Function
REQ-014 cmd_ready_o SHALL be high only in S_IDLE.
REQ-015 States: S_IDLE, S_FETCH, S_REQ, S_BUSY, S_DONE.
REQ-016 S_IDLE: on command accept latch we/addr/len; len=0 -> S_DONE, else -> S_FETCH.
REQ-017 S_FETCH write: wr_ready_o high; on wr_valid_i capture wr_data_i into m_dat_o, -> S_REQ.
REQ-018 S_FETCH read: -> S_REQ only when FIFO count + 1 <= RD_FIFO_DEPTH; else hold.
REQ-019 S_REQ: m_stb_o=1, m_we_o=latched we, m_addr_o=current address; hold until m_cyc_i=1, then m_stb_o=0, -> S_BUSY.
REQ-020 S_BUSY: wait m_cyc_i 1->0; that cycle = word complete; read bursts push m_dat_i into FIFO same edge.
REQ-021 Per completed word: address +1 (mod 2^32), remaining -1; remaining 0 -> S_DONE, else -> S_FETCH.
REQ-022 S_DONE: done_o=1 one cycle, -> S_IDLE; earliest next cmd_ready_o the following cycle.
REQ-023 wr_ready_o SHALL be 0 outside S_FETCH of a write burst; at most one word consumed per downstream transaction.
REQ-024 FIFO: simultaneous push and pop SHALL both occur, count unchanged; pop on empty and push on full never occur (REQ-018 guarantees).
REQ-025 rd_valid_o = FIFO not empty; data leaves only on rd_valid_o && rd_ready_i; FIFO drains after done_o.
REQ-026 cmd_len_i > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-027 m_stb_o SHALL never be high while in S_BUSY; one transaction outstanding max.

Reset
REQ-028 rst_i: state S_IDLE, FIFO emptied, m_stb_o=0, m_we_o=0, m_addr_o=0, m_dat_o=0, done_o=0, wr_ready_o=0, rd_valid_o=0, cmd_ready_o=1 next cycle.
REQ-029 Reset mid-burst SHALL abandon the burst without done_o; downstream port shares rst_i.

Structure
REQ-030 Package sdram_pkg: state enum, MAX_LEN default, address/data width constants.
REQ-031 Sub-module sdram_rd_fifo: synchronous FIFO, push/pop/count/empty/full.

Verification
REQ-032 Write cmd addr 0x100 len 4, data 0xA0..0xA3 -> four downstream writes to 0x100..0x103 in order, one done_o.
REQ-033 Read cmd addr 0x200 len 8, rd_ready_i=0 -> exactly 4 transactions then stall; raise rd_ready_i -> remaining 4 issue, 8 words out in order.
REQ-034 Write burst with wr_valid_i gaps of 3 cycles -> m_stb_o stays low during gaps, no duplicated/skipped word.
REQ-035 cmd_len_i=0 -> no m_stb_o, done_o 1 cycle after accept; addr 0xFFFFFFFF len 2 -> second word at 0x00000000.
REQ-036 rst_i asserted during S_BUSY of word 3 of 6 -> all outputs at reset values next cycle, no done_o, FIFO empty.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM burst master and its read FIFO.
package sdram_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 16;
  localparam int LEN_W           = 9;
  localparam int MAX_LEN_DEFAULT = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_BUSY,
    S_DONE
  } state_e;

  // Limit a requested word count to the largest burst the master supports.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      max_len);
    if (32'(len) > max_len) begin
      return LEN_W'(max_len);
    end
    return len;
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Small synchronous FIFO buffering downstream read data until the consumer
// takes it. The head word is presented combinationally so rd_data_o is valid
// in the same cycle as rd_valid_o. Callers never push when full or pop when
// empty; the burst master only issues a read when a free slot exists.
module sdram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage array: written on push, no reset needed since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sdram_burst_master.sv
// Burst master: turns one burst command into a sequence of single-word
// downstream transactions, one outstanding at a time. Write bursts pull one
// word from the write stream per transaction; read bursts only issue a
// transaction when the read FIFO has room for its result.
module sdram_burst_master
  import sdram_pkg::*;
#(
  parameter int RD_FIFO_DEPTH = 4,
  parameter int MAX_LEN       = MAX_LEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // burst command
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  // write-data stream
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  // read-data stream
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  // completion
  output logic              done_o,
  // downstream port
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_dat_o,
  input  logic              m_cyc_i,
  input  logic [DATA_W-1:0] m_dat_i
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  logic [LEN_W-1:0]  cmd_len_clamped;
  logic              word_done;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_room;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign cmd_len_clamped = clamp_len(cmd_len_i, MAX_LEN);

  // A word finishes on the first cycle the downstream cycle signal is low
  // while busy; entry to S_BUSY requires it to have been high.
  assign word_done = (state_q == S_BUSY) && !m_cyc_i;
  assign fifo_push = word_done && !we_q && !fifo_full;
  assign fifo_pop  = !fifo_empty && rd_ready_i;
  assign fifo_room = (int'(fifo_count) + 1) <= RD_FIFO_DEPTH;

  sdram_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (m_dat_i),
    .pop_i       (fifo_pop),
    .head_o      (rd_data_o),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    dat_d    = dat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d     = cmd_we_i;
          addr_d   = cmd_addr_i;
          remain_d = cmd_len_clamped;
          state_d  = (cmd_len_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (we_q) begin
          if (wr_valid_i) begin
            dat_d   = wr_data_i;
            state_d = S_REQ;
          end
        end else if (fifo_room) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (m_cyc_i) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!m_cyc_i) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          state_d  = (remain_q == LEN_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      dat_q    <= dat_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign wr_ready_o  = (state_q == S_FETCH) && we_q;
  assign rd_valid_o  = !fifo_empty;
  assign done_o      = (state_q == S_DONE);
  assign m_stb_o     = (state_q == S_REQ);
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_dat_o     = dat_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Self-checking bench for sdram_burst_master: a table of bursts plus random
// bursts checked against a transaction-level model, and hand-written
// sequences for stalls, zero-length bursts and mid-burst reset.
module tb_sdram_burst_master;

  localparam int MAXL = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [8:0]  cmd_len_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [15:0] wr_data_i = '0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic [15:0] rd_data_o;
  logic        done_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [15:0] m_dat_o;
  logic        m_cyc_i = 1'b0;
  logic [15:0] m_dat_i = '0;

  sdram_burst_master dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .done_o      (done_o),
    .m_stb_o     (m_stb_o),
    .m_we_o      (m_we_o),
    .m_addr_o    (m_addr_o),
    .m_dat_o     (m_dat_o),
    .m_cyc_i     (m_cyc_i),
    .m_dat_i     (m_dat_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // transaction logs and stimulus queues
  logic [31:0] tx_addr_log[$];
  logic        tx_we_log[$];
  logic [15:0] tx_dat_log[$];
  logic [15:0] rd_log[$];
  logic [15:0] wr_src[$];
  logic [15:0] exp_wdat[$];

  int done_cnt    = 0;
  int stb_viol    = 0;
  int wr_gap      = 0;
  int rd_mode     = 1;
  int sl_max      = 2;
  int sl_hold_min = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    int          len;
    int          gap;
    int          rdmode;
    int          exp_ntx;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  // Contents of the downstream memory as seen by read transactions.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Downstream slave: grants after a random delay, holds cyc, then ends the word.
  initial begin
    int          phase;
    int          cnt;
    logic [31:0] cur_addr;
    phase = 0;
    cnt = 0;
    cur_addr = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        phase = 0;
        m_cyc_i = 1'b0;
      end else begin
        case (phase)
          0: begin
            if (m_stb_o) begin
              tx_addr_log.push_back(m_addr_o);
              tx_we_log.push_back(m_we_o);
              tx_dat_log.push_back(m_dat_o);
              cur_addr = m_addr_o;
              cnt = int'($urandom_range(0, sl_max));
              if (cnt == 0) begin
                m_cyc_i = 1'b1;
                phase = 2;
                cnt = sl_hold_min + int'($urandom_range(0, sl_max));
              end else begin
                phase = 1;
              end
            end
          end
          1: begin
            if (!m_stb_o) stb_viol++;
            cnt--;
            if (cnt == 0) begin
              m_cyc_i = 1'b1;
              phase = 2;
              cnt = sl_hold_min + int'($urandom_range(0, sl_max));
            end
          end
          default: begin
            if (m_stb_o) stb_viol++;
            if (cnt == 0) begin
              m_cyc_i = 1'b0;
              m_dat_i = mem_word(cur_addr);
              phase = 0;
            end else begin
              cnt--;
            end
          end
        endcase
      end
    end
  end

  // Read-data sink: ready pattern by rd_mode (0 low, 1 high, 2 random).
  initial forever begin
    @(negedge clk_i);
    case (rd_mode)
      0:       rd_ready_i = 1'b0;
      1:       rd_ready_i = 1'b1;
      default: rd_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (rd_valid_o && rd_ready_i) rd_log.push_back(rd_data_o);
  end

  // Write-data source with an idle gap of wr_gap cycles after each accepted word.
  initial begin
    int gap_cnt;
    gap_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (gap_cnt > 0) begin
        gap_cnt--;
        wr_valid_i = 1'b0;
      end else if (wr_src.size() > 0) begin
        wr_valid_i = 1'b1;
        wr_data_i = wr_src[0];
        if (wr_ready_o) begin
          void'(wr_src.pop_front());
          gap_cnt = wr_gap;
        end
      end else begin
        wr_valid_i = 1'b0;
      end
    end
  end

  // Count completion pulses.
  initial forever begin
    @(negedge clk_i);
    if (done_o) done_cnt++;
  end

  // Global time limit.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    tx_addr_log.delete();
    tx_we_log.delete();
    tx_dat_log.delete();
    rd_log.delete();
    done_cnt = 0;
    stb_viol = 0;
  endtask

  // Present a command and return at the negedge after the accepting edge.
  task automatic issue_cmd(input bit we, input logic [31:0] addr, input logic [8:0] len);
    int k;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i = we;
    cmd_addr_i = addr;
    cmd_len_i = len;
    k = 0;
    while (!cmd_ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 200) chk("cmd_accept_timeout", 32'(k), 32'd0);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= budget) chk("done_timeout", 32'(done_cnt), 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_rd(input int n);
    int k;
    k = 0;
    while (rd_log.size() < n && k < 200) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  // Compare logs against the expected burst: consecutive addresses from addr,
  // write data in stream order, read data from the slave memory.
  task automatic compare_burst(input string nm, input bit we, input logic [31:0] addr, input int n);
    int bad;
    int m;
    chk({nm, "/ntx"}, 32'(tx_addr_log.size()), 32'(n));
    m = (tx_addr_log.size() < n) ? tx_addr_log.size() : n;
    bad = 0;
    for (int i = 0; i < m; i++) begin
      if (tx_addr_log[i] !== addr + 32'(i)) bad++;
      else if (tx_we_log[i] !== we) bad++;
      else if (we && tx_dat_log[i] !== exp_wdat[i]) bad++;
    end
    chk({nm, "/tx_errs"}, 32'(bad), 32'd0);
    if (!we) begin
      chk({nm, "/nrd"}, 32'(rd_log.size()), 32'(n));
      m = (rd_log.size() < n) ? rd_log.size() : n;
      bad = 0;
      for (int i = 0; i < m; i++) begin
        if (rd_log[i] !== mem_word(addr + 32'(i))) bad++;
      end
      chk({nm, "/rd_errs"}, 32'(bad), 32'd0);
    end
    chk({nm, "/done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "/stb_viol"}, 32'(stb_viol), 32'd0);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int n;
    n = (v.len > MAXL) ? MAXL : v.len;
    clear_logs();
    exp_wdat.delete();
    if (v.we) begin
      for (int i = 0; i < n; i++) exp_wdat.push_back(16'($urandom));
    end
    wr_src = exp_wdat;
    wr_gap = v.gap;
    rd_mode = v.rdmode;
    issue_cmd(v.we, v.addr, 9'(v.len));
    wait_done(n * 40 + 50);
    if (!v.we) wait_rd(n);
    compare_burst(nm, v.we, v.addr, n);
    chk({nm, "/exp_ntx"}, 32'(tx_addr_log.size()), 32'(v.exp_ntx));
    if (v.exp_ntx > 0 && tx_addr_log.size() > 0)
      chk({nm, "/last_addr"}, tx_addr_log[tx_addr_log.size()-1], v.exp_last);
    wr_src.delete();
    $display("burst %s we=%0d addr=%08h len=%0d ntx=%0d nrd=%0d done=%0d",
             nm, v.we, v.addr, v.len, tx_addr_log.size(), rd_log.size(), done_cnt);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "/cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({nm, "/m_stb"},     32'(m_stb_o),     32'd0);
    chk({nm, "/m_we"},      32'(m_we_o),      32'd0);
    chk({nm, "/m_addr"},    m_addr_o,         32'd0);
    chk({nm, "/m_dat"},     32'(m_dat_o),     32'd0);
    chk({nm, "/done"},      32'(done_o),      32'd0);
    chk({nm, "/wr_ready"},  32'(wr_ready_o),  32'd0);
    chk({nm, "/rd_valid"},  32'(rd_valid_o),  32'd0);
  endtask

  // Reset while word 3 of a 6-word burst is in its busy phase.
  task automatic reset_mid(input bit we);
    int k;
    string nm;
    nm = we ? "rst_mid_wr" : "rst_mid_rd";
    clear_logs();
    sl_hold_min = 2;
    rd_mode = 0;
    wr_gap = 0;
    exp_wdat.delete();
    if (we) begin
      for (int i = 0; i < 6; i++) exp_wdat.push_back(16'($urandom_range(1, 16'hFFFF)));
    end
    wr_src = exp_wdat;
    issue_cmd(we, 32'h0000_0700, 9'd6);
    k = 0;
    while (tx_addr_log.size() < 3 && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    while (m_stb_o && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    chk({nm, "/reached_word3"}, 32'(k < 300), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs(nm);
    @(negedge clk_i);
    rst_i = 1'b0;
    wr_src.delete();
    sl_hold_min = 0;
    rd_mode = 1;
    repeat (6) @(negedge clk_i);
    chk({nm, "/no_done"}, 32'(done_cnt), 32'd0);
    chk({nm, "/fifo_empty"}, 32'(rd_valid_o), 32'd0);
    chk({nm, "/ntx"}, 32'(tx_addr_log.size()), 32'd3);
    $display("burst %s we=%0d addr=00000700 len=6 ntx=%0d (reset in word 3)",
             nm, we, tx_addr_log.size());
  endtask

  initial begin
    vec_t rv;
    // {we, addr, len, gap, rdmode, expected transactions, expected last address}
    vecs[0] = '{1'b1, 32'h0000_0100, 4,   0, 1, 4,   32'h0000_0103};
    vecs[1] = '{1'b1, 32'h0000_0300, 5,   3, 1, 5,   32'h0000_0304};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 2,   0, 1, 2,   32'h0000_0000};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 3,   1, 1, 3,   32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_1000, 300, 0, 1, 256, 32'h0000_10FF};
    vecs[5] = '{1'b0, 32'h0000_0040, 1,   0, 2, 1,   32'h0000_0040};
    vecs[6] = '{1'b1, 32'h0000_0050, 0,   0, 1, 0,   32'h0000_0000};

    // reset state
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset/cmd_ready", 32'(cmd_ready_o), 32'd1);

    // table-driven bursts
    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // zero-length burst: done one cycle after accept, no downstream request
    clear_logs();
    issue_cmd(1'b1, 32'h0000_0500, 9'd0);
    chk("len0/done_next_cycle", 32'(done_o), 32'd1);
    chk("len0/no_stb", 32'(m_stb_o), 32'd0);
    @(negedge clk_i);
    chk("len0/done_one_cycle", 32'(done_o), 32'd0);
    chk("len0/ready_again", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    chk("len0/ntx", 32'(tx_addr_log.size()), 32'd0);
    chk("len0/done_cnt", 32'(done_cnt), 32'd1);
    $display("burst len0 we=1 addr=00000500 len=0 ntx=%0d done=%0d", tx_addr_log.size(), done_cnt);

    // read stall: FIFO of 4 fills, master holds, then resumes when drained
    clear_logs();
    rd_mode = 0;
    issue_cmd(1'b0, 32'h0000_0200, 9'd8);
    repeat (150) @(negedge clk_i);
    chk("stall/ntx", 32'(tx_addr_log.size()), 32'd4);
    chk("stall/rd_valid", 32'(rd_valid_o), 32'd1);
    chk("stall/no_done", 32'(done_cnt), 32'd0);
    chk("stall/no_stb", 32'(m_stb_o), 32'd0);
    rd_mode = 1;
    wait_done(400);
    wait_rd(8);
    compare_burst("stall", 1'b0, 32'h0000_0200, 8);
    $display("burst stall we=0 addr=00000200 len=8 ntx=%0d nrd=%0d", tx_addr_log.size(), rd_log.size());

    // mid-burst reset
    reset_mid(1'b0);
    reset_mid(1'b1);

    // random bursts against the model
    for (int i = 0; i < 20; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      rv.len = int'($urandom_range(0, 10));
      rv.gap = int'($urandom_range(0, 3));
      rv.rdmode = int'($urandom_range(1, 2));
      rv.exp_ntx = rv.len;
      rv.exp_last = rv.addr + 32'(rv.len) - 32'd1;
      run_vec($sformatf("rnd%0d", i), rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
